// File: rtl/proc_8085_pkg.sv
// proc_8085_pkg: state encoding, opcode constants, alu codes and register indices shared by the 8085 control slice
package proc_8085_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_OPND,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_MOV_RA,
        C_MOV_AR,
        C_ALU,
        C_JMP,
        C_JZ,
        C_JC,
        C_HLT,
        C_ILL
    } iclass_t;

    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] OP_NOP   = 8'h7F;
    localparam logic [7:0] OP_JMP   = 8'hC3;
    localparam logic [7:0] OP_JZ    = 8'hCA;
    localparam logic [7:0] OP_JC    = 8'hDA;
    localparam logic [7:0] MOV_MASK = 8'hC0;
    localparam logic [7:0] MOV_VAL  = 8'h40;
    localparam logic [7:0] ALU_MASK = 8'hF8;
    localparam logic [7:0] OP_ADD   = 8'h80;
    localparam logic [7:0] OP_SUB   = 8'h90;
    localparam logic [7:0] OP_ANA   = 8'hA0;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;

    // only B..L live in the register file; M and A are not addressable there
    function automatic logic is_rf(input logic [2:0] r);
        return r <= REG_L;
    endfunction

endpackage

// File: rtl/proc_8085_decode.sv
// proc_8085_decode: combinational classification of the instruction register
module proc_8085_decode
    import proc_8085_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] cls,
    output logic [2:0] src,
    output logic [2:0] dst,
    output logic [1:0] alu_op,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        alu_op = ALU_ADD;
        if (ir == OP_HLT)
            cls = C_HLT;
        else if (ir == OP_NOP)
            cls = C_NOP;
        else if (ir == OP_JMP)
            cls = C_JMP;
        else if (ir == OP_JZ)
            cls = C_JZ;
        else if (ir == OP_JC)
            cls = C_JC;
        else if ((ir & MOV_MASK) == MOV_VAL) begin
            if (ir[5:3] == REG_A && is_rf(ir[2:0]))
                cls = C_MOV_AR;
            else if (ir[2:0] == REG_A && is_rf(ir[5:3]))
                cls = C_MOV_RA;
        end else if (is_rf(ir[2:0])) begin
            if ((ir & ALU_MASK) == OP_ADD) begin
                cls = C_ALU;
                alu_op = ALU_ADD;
            end else if ((ir & ALU_MASK) == OP_SUB) begin
                cls = C_ALU;
                alu_op = ALU_SUB;
            end else if ((ir & ALU_MASK) == OP_ANA) begin
                cls = C_ALU;
                alu_op = ALU_AND;
            end
        end
    end

    assign src = ir[2:0];
    assign dst = ir[5:3];
    assign illegal = cls == C_ILL;

endmodule

// File: rtl/proc_8085_ctrl_fsm.sv
// proc_8085_ctrl_fsm: fetch/decode/execute controller driving the 8085 register file, ALU and accumulator
module proc_8085_ctrl_fsm
    import proc_8085_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mem_rdata,
    input  logic       z,
    input  logic       cy,
    output logic [7:0] mem_addr,
    output logic [2:0] rf_rd_sel,
    output logic       rf_wr_en,
    output logic [2:0] rf_wr_sel,
    output logic       acc_load,
    output logic       acc_src,
    output logic [1:0] alu_op,
    output logic       flag_load,
    output logic       halted,
    output logic       illegal
);

    state_t     state, state_nx;
    logic [7:0] pc, pc_nx, ir, ir_nx;
    logic [3:0] cls;
    logic [2:0] src, dst;
    logic [1:0] dec_alu;
    logic       dec_ill, is_jump, take, exec;

    proc_8085_decode u_decode (
        .ir      (ir),
        .cls     (cls),
        .src     (src),
        .dst     (dst),
        .alu_op  (dec_alu),
        .illegal (dec_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc <= PC_RESET;
            ir <= 8'h00;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            ir <= ir_nx;
        end
    end

    assign is_jump = cls == C_JMP || cls == C_JZ || cls == C_JC;
    // flags are sampled in OPND, after any preceding EXEC has committed them
    assign take = cls == C_JMP || (cls == C_JZ && z) || (cls == C_JC && cy);

    always_comb begin
        state_nx = state;
        pc_nx = pc;
        ir_nx = ir;
        case (state)
            S_FETCH: begin
                ir_nx = mem_rdata;
                pc_nx = pc + 8'd1;
                state_nx = S_DECODE;
            end
            S_DECODE: state_nx = is_jump ? S_OPND : (cls == C_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = S_FETCH;
            S_OPND: begin
                pc_nx = take ? mem_rdata : pc + 8'd1;
                state_nx = S_FETCH;
            end
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    assign exec      = state == S_EXEC;
    assign mem_addr  = pc;
    assign rf_wr_en  = exec && cls == C_MOV_RA;
    assign rf_wr_sel = rf_wr_en ? dst : 3'd0;
    assign acc_load  = exec && (cls == C_MOV_AR || cls == C_ALU);
    assign acc_src   = exec && cls == C_MOV_AR;
    assign rf_rd_sel = acc_load ? src : 3'd0;
    assign flag_load = exec && cls == C_ALU;
    assign alu_op    = flag_load ? dec_alu : ALU_ADD;
    assign illegal   = exec && dec_ill;
    assign halted    = state == S_HALT;

endmodule

// File: tb/tb_proc_8085_ctrl_fsm.sv
// tb_proc_8085_ctrl_fsm: scoreboard bench; an instruction-level ISA model predicts every strobe event of the controller
module tb_proc_8085_ctrl_fsm;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic [13:0] v;
    } ev_t;

    localparam logic [13:0] V_HALT = 14'h2000;
    localparam logic [13:0] V_ILL  = 14'h1000;

    logic       clk, reset, z, cy;
    logic [7:0] mem_rdata, mem_addr;
    logic [2:0] rf_rd_sel, rf_wr_sel;
    logic       rf_wr_en, acc_load, acc_src, flag_load, halted, illegal;
    logic [1:0] alu_op;

    logic [7:0]  rom [256];
    logic [13:0] tab [256];
    logic        zarr [512];
    logic        cyarr [512];
    ev_t         q [$];
    ev_t         me;
    int          cyc, lim, nchk, npass;
    logic        hq;
    logic [7:0]  hpc;
    logic [13:0] obs;

    assign mem_rdata = rom[mem_addr];

    proc_8085_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .z         (z),
        .cy        (cy),
        .mem_addr  (mem_addr),
        .rf_rd_sel (rf_rd_sel),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_sel (rf_wr_sel),
        .acc_load  (acc_load),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .flag_load (flag_load),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle 1 is the FETCH that ends on the first rising edge after reset release
    always @(posedge clk or posedge reset) begin
        if (reset)
            cyc <= 1;
        else
            cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // vector layout: {halted, illegal, wr_en, wr_sel[3], acc_load, acc_src, rd_sel[3], alu_op[2], flag_load}
    function automatic logic [13:0] mk(input logic wr, input logic [2:0] ws, input logic al,
                                       input logic as, input logic [2:0] rs, input logic [1:0] op,
                                       input logic fl);
        return {1'b0, 1'b0, wr, ws, al, as, rs, op, fl};
    endfunction

    task automatic build_tab();
        logic [2:0] rr;
        for (int i = 0; i < 256; i++) tab[i] = V_ILL;
        for (int r = 0; r < 6; r++) begin
            rr = r[2:0];
            tab[8'h47 + 8 * r] = mk(1'b1, rr, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
            tab[8'h78 + r]     = mk(1'b0, 3'd0, 1'b1, 1'b1, rr, 2'd0, 1'b0);
            tab[8'h80 + r]     = mk(1'b0, 3'd0, 1'b1, 1'b0, rr, 2'd0, 1'b1);
            tab[8'h90 + r]     = mk(1'b0, 3'd0, 1'b1, 1'b0, rr, 2'd1, 1'b1);
            tab[8'hA0 + r]     = mk(1'b0, 3'd0, 1'b1, 1'b0, rr, 2'd2, 1'b1);
        end
        tab[8'h7F] = 14'h0;
        tab[8'hC3] = 14'h0;
        tab[8'hCA] = 14'h0;
        tab[8'hDA] = 14'h0;
        tab[8'h76] = V_HALT;
    endtask

    // instruction-level model: each instruction costs 3 cycles, its effect shows in its third cycle
    task automatic model_run(input int ncyc);
        logic [7:0] p, op;
        logic       tk;
        int         c;
        ev_t        e;
        p = 8'h00;
        c = 1;
        while (c + 2 <= ncyc) begin
            op = rom[p];
            p = p + 8'd1;
            e.cyc = c + 2;
            e.pc = p;
            e.v = tab[op];
            if (op == 8'hC3 || op == 8'hCA || op == 8'hDA) begin
                tk = op == 8'hC3 || (op == 8'hCA && zarr[c + 2]) || (op == 8'hDA && cyarr[c + 2]);
                p = tk ? rom[p] : p + 8'd1;
            end else if (e.v != 14'h0)
                q.push_back(e);
            if (op == 8'h76) break;
            c += 3;
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic rand_rom();
        int unsigned r;
        logic [7:0]  k;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 99);
            k = 8'($urandom_range(0, 5));
            if (r < 30)
                rom[i] = 8'($urandom);
            else if (r < 60)
                rom[i] = 8'h80 + 8'($urandom_range(0, 2) * 16) + k;
            else if (r < 80)
                rom[i] = $urandom_range(0, 1) ? 8'h47 + (k << 3) : 8'h78 + k;
            else if (r < 95)
                rom[i] = (r < 85) ? 8'hC3 : (r < 90) ? 8'hCA : 8'hDA;
            else
                rom[i] = (r < 98) ? 8'h7F : 8'h76;
        end
    endtask

    // flag modes: 0/1 hold that value every cycle, 2 randomises per cycle
    task automatic run_prog(input int ncyc, input int zm, input int cm);
        reset = 1'b1;
        #1;
        chk("reset_outputs", {halted, illegal, rf_wr_en, rf_wr_sel, acc_load, acc_src,
                              rf_rd_sel, alu_op, flag_load, mem_addr}, 32'h0);
        for (int i = 0; i < 512; i++) begin
            zarr[i]  = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
            cyarr[i] = (cm == 2) ? 1'($urandom_range(0, 1)) : (cm == 1);
        end
        q.delete();
        model_run(ncyc);
        lim = ncyc;
        @(negedge clk);
        reset = 1'b0;
        z = zarr[1];
        cy = cyarr[1];
        repeat (ncyc - 1) begin
            @(negedge clk);
            z = zarr[cyc];
            cy = cyarr[cyc];
        end
        #1 reset = 1'b1;
        chk("leftover_events", q.size(), 0);
    endtask

    initial begin
        hq = 1'b0;
        hpc = 8'h00;
        forever begin
            @(negedge clk);
            obs = {halted, illegal, rf_wr_en, rf_wr_sel, acc_load, acc_src, rf_rd_sel, alu_op, flag_load};
            if (reset || cyc > lim)
                hq = 1'b0;
            else if (hq)
                chk("halt_hold", {obs, mem_addr}, {V_HALT, hpc});
            else if (obs != 14'h0) begin
                if (q.size() == 0)
                    chk("unexpected_event", obs, 0);
                else begin
                    me = q.pop_front();
                    chk("event_cycle", cyc, me.cyc);
                    chk("event_outputs", obs, me.v);
                    chk("event_pc", mem_addr, me.pc);
                    hq = me.v[13] && obs[13];
                    hpc = me.pc;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        z = 1'b0;
        cy = 1'b0;
        nchk = 0;
        npass = 0;
        lim = 0;
        build_tab();
        repeat (2) @(negedge clk);
        fill(8'h76); rom[0] = 8'h80;
        run_prog(6, 0, 0);
        fill(8'h76); rom[0] = 8'h47; rom[1] = 8'h7A;
        run_prog(10, 0, 0);
        fill(8'h76); rom[0] = 8'hCA; rom[1] = 8'h40;
        run_prog(8, 1, 0);
        run_prog(8, 0, 1);
        fill(8'h76); rom[0] = 8'hDA; rom[1] = 8'h40;
        run_prog(8, 0, 1);
        run_prog(8, 1, 0);
        fill(8'h76); rom[0] = 8'hC3; rom[1] = 8'hFF; rom[8'hFF] = 8'h00;
        run_prog(12, 0, 0);
        fill(8'h76); rom[0] = 8'h80;
        run_prog(3, 0, 0);
        fill(8'h00); rom[0] = 8'h76;
        run_prog(25, 0, 0);
        repeat (40) begin
            rand_rom();
            run_prog(60, 2, 2);
        end
        #1;
        chk("final_reset_outputs", {halted, illegal, rf_wr_en, rf_wr_sel, acc_load, acc_src,
                                    rf_rd_sel, alu_op, flag_load, mem_addr}, 32'h0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/proc_8085_ctrl_fsm.md
PROC_8085_CTRL_FSM -- requirements
Module: proc_8085_ctrl_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: mem_rdata  in  8  program-ROM data, combinational read of mem_addr.
REQ-004 SHALL have: z, cy  in  1 each  accumulator flags from datapath.
REQ-005 SHALL have: mem_addr  out  8  equals pc register at all times.
REQ-006 SHALL have: rf_rd_sel  out  3  register-file read index (0..5 = B,C,D,E,H,L).
REQ-007 SHALL have: rf_wr_en  out  1, rf_wr_sel  out  3  register-file write strobe/index.
REQ-008 SHALL have: acc_load  out  1, acc_src  out  1 (0 = ALU result, 1 = rf read data).
REQ-009 SHALL have: alu_op  out  2 (0 ADD, 1 SUB, 2 AND), flag_load  out  1.
REQ-010 SHALL have: halted  out  1 level, illegal  out  1 one-cycle pulse.
REQ-011 SHALL have parameter PC_RESET, default 8'h00, pc value after reset.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, OPND, HALT; register ir[7:0], pc[7:0].
REQ-013 FETCH: ir <= mem_rdata, pc <= pc+1 (8-bit wrap, FF->00), next DECODE.
REQ-014 DECODE: classify ir, no datapath strobes; next OPND for jumps, HALT for 8'h76, else EXEC.
REQ-015 MOV r,A (01 ddd 111, ddd 0..5): EXEC asserts rf_wr_en, rf_wr_sel=ddd; next FETCH.
REQ-016 MOV A,r (01 111 sss, sss 0..5): EXEC asserts acc_load, acc_src=1, rf_rd_sel=sss; flags untouched.
REQ-017 ADD/SUB/ANA r (10000sss/10010sss/10100sss): EXEC asserts rf_rd_sel=sss, acc_load, acc_src=0, alu_op 0/1/2, flag_load.
REQ-018 MOV A,A (8'h7F) SHALL be a 3-cycle NOP with no strobes.
REQ-019 JMP 8'hC3, JZ 8'hCA, JC 8'hDA: OPND reads target at mem_addr=pc; if JMP, or JZ with z=1, or JC with cy=1, pc <= mem_rdata, else pc <= pc+1; next FETCH.
REQ-020 Condition SHALL be sampled in OPND cycle (flags from preceding EXEC already committed).
REQ-021 Any other opcode, or register field 6 (M), SHALL pulse illegal in EXEC, no other strobes, next FETCH.
REQ-022 HALT: halted=1, pc frozen, all strobes 0, exit only by reset.
REQ-023 Latency: ALU/MOV instructions 3 cycles, jumps 3 cycles, HLT reaches HALT 2 cycles after FETCH.
REQ-024 All strobes SHALL be Moore outputs decoded from state and ir, asserted exactly one cycle.
REQ-025 rf_rd_sel/rf_wr_sel/alu_op SHALL be 0 whenever their strobe is inactive.

Reset
REQ-026 reset SHALL force state=FETCH, pc=PC_RESET, ir=8'h00, all outputs 0 except mem_addr=PC_RESET.
REQ-027 reset mid-instruction SHALL abort it; no strobe asserts in the reset cycle or after release before the next FETCH completes.
REQ-028 First FETCH SHALL occur on the first rising clk edge with reset low.

Structure
REQ-029 Shared package proc_8085_pkg SHALL hold state encoding, opcode constants (HLT, JMP, JZ, JC, MOV/ADD/SUB/ANA masks), alu_op codes, register indices.
REQ-030 Sub-module proc_8085_decode (combinational ir -> instruction class, src, dst, alu_op, illegal) is natural; FSM and pc stay in top.
REQ-031 Block drives the existing register file, ALU and accumulator; it contains no datapath storage.

Verification
REQ-032 Reset with PC_RESET=0, ROM[0]=8'h80 (ADD B): cycle 3 shows rf_rd_sel=0, acc_load=1, alu_op=0, flag_load=1; pc=1.
REQ-033 ROM 0..1 = 8'h47 (MOV B,A), 8'h7A (MOV A,D): rf_wr_en with rf_wr_sel=0 at cycle 3, acc_load with acc_src=1, rf_rd_sel=2 at cycle 6.
REQ-034 ROM 0..1 = 8'hCA, 8'h40: z=1 -> pc=8'h40 after OPND; z=0 -> pc=8'h02; repeat JC with cy.
REQ-035 ROM[8'hFF]=8'h00 (illegal), pc=8'hFF: illegal pulses once, pc wraps to 8'h00.
REQ-036 ROM[0]=8'h76: halted=1 from cycle 3, pc stays 1 for 20 cycles; reset asserted mid-HALT and mid-EXEC returns pc=0, outputs 0.
